// File: rtl/uart_rx_drain_ctrl_if.sv
// Output channel of the UART receive drain: one received character plus its status bits,
// moved under a valid/ready handshake toward the DMA/host side.
interface uart_rx_drain_ctrl_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_status;

    modport master (output out_valid, output out_data, output out_status, input out_ready);
    modport slave  (input out_valid, input out_data, input out_status, output out_ready);
endinterface

// File: rtl/uart_rx_drain_ctrl.sv
// Receive-side drain scheduler: pops the UART RX FIFO into a single-entry output register
// and produces registered receive-data, timeout and error interrupts.
module uart_rx_drain_ctrl #(
    parameter int FIFO_COUNTER_W = 5,
    parameter int REC_WIDTH      = 11,
    parameter int BURST          = 8
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      rx_reset,
    input  logic [FIFO_COUNTER_W-1:0] rf_count,
    input  logic [REC_WIDTH-1:0]      rf_data_out,
    input  logic [9:0]                counter_t,
    input  logic [1:0]                fcr_trig,
    input  logic                      force_drain,
    input  logic                      err_clr,
    output logic                      rf_pop,
    output logic                      rda_int,
    output logic                      ti_int,
    output logic                      err_int,
    output logic [7:0]                err_count,
    uart_rx_drain_ctrl_if.master      drain
);
    localparam int         CW      = (FIFO_COUNTER_W > 4) ? FIFO_COUNTER_W : 4;
    localparam logic [3:0] BURST_C = 4'(BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  burst_cnt_r;
    logic        rf_pop_r;
    logic        out_valid_r;
    logic [7:0]  out_data_r;
    logic [2:0]  out_status_r;
    logic        rda_int_r;
    logic        ti_int_r;
    logic        err_int_r;
    logic [7:0]  err_count_r;

    logic [CW-1:0] trig_lvl_s;
    logic [CW-1:0] count_ext_s;
    logic          fifo_empty_s;
    logic          rda_cond_s;
    logic          ti_cond_s;
    logic          start_s;
    logic          buf_free_s;
    logic          load_s;
    logic          load_err_s;

    function automatic logic status_has_err(input logic [2:0] status);
        return (status != 3'b000);
    endfunction

    // Trigger decode, drain start condition and the load decision for this cycle.
    always_comb begin
        count_ext_s = CW'(rf_count);
        case (fcr_trig)
            2'b00:   trig_lvl_s = CW'(4'd1);
            2'b01:   trig_lvl_s = CW'(4'd4);
            2'b10:   trig_lvl_s = CW'(4'd8);
            2'b11:   trig_lvl_s = CW'(4'd14);
            default: trig_lvl_s = CW'(4'd1);
        endcase
        fifo_empty_s = (rf_count == {FIFO_COUNTER_W{1'b0}});
        rda_cond_s   = (count_ext_s >= trig_lvl_s);
        ti_cond_s    = (counter_t == 10'd0) && !fifo_empty_s;
        start_s      = rda_cond_s || ti_cond_s || (force_drain && !fifo_empty_s);
        buf_free_s   = !out_valid_r || drain.out_ready;
        // rx_reset suppresses the load so a flushed FIFO head is never captured.
        if (!rx_reset && (state_r == S_DRAIN) && !fifo_empty_s &&
            (burst_cnt_r != BURST_C) && buf_free_s) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        load_err_s = load_s && status_has_err(rf_data_out[2:0]);
    end

    // Drain FSM, output register, interrupts and error bookkeeping.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r      <= S_IDLE;
            burst_cnt_r  <= 4'd0;
            rf_pop_r     <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 8'd0;
            out_status_r <= 3'd0;
            rda_int_r    <= 1'b0;
            ti_int_r     <= 1'b0;
            err_int_r    <= 1'b0;
            err_count_r  <= 8'd0;
        end else begin
            rda_int_r <= rda_cond_s;
            ti_int_r  <= ti_cond_s;

            if (load_err_s) begin
                err_int_r <= 1'b1;
            end else if (err_clr) begin
                err_int_r <= 1'b0;
            end
            if (load_err_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end

            if (rx_reset) begin
                state_r     <= S_IDLE;
                rf_pop_r    <= 1'b0;
                out_valid_r <= 1'b0;
                burst_cnt_r <= 4'd0;
            end else begin
                if (load_s) begin
                    out_data_r   <= rf_data_out[10:3];
                    out_status_r <= rf_data_out[2:0];
                    out_valid_r  <= 1'b1;
                    rf_pop_r     <= 1'b1;
                end else begin
                    rf_pop_r <= 1'b0;
                    if (out_valid_r && drain.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end

                case (state_r)
                    S_IDLE: begin
                        if (start_s) begin
                            state_r     <= S_DRAIN;
                            burst_cnt_r <= 4'd0;
                        end
                    end
                    S_DRAIN: begin
                        if (fifo_empty_s || (burst_cnt_r == BURST_C)) begin
                            state_r <= S_IDLE;
                        end else if (load_s) begin
                            burst_cnt_r <= burst_cnt_r + 4'd1;
                            state_r     <= S_GAP;
                        end
                    end
                    // One spare cycle so rf_count reflects the pop before the next decision.
                    S_GAP:   state_r <= S_DRAIN;
                    default: state_r <= S_IDLE;
                endcase
            end
        end
    end

    assign rf_pop           = rf_pop_r;
    assign rda_int          = rda_int_r;
    assign ti_int           = ti_int_r;
    assign err_int          = err_int_r;
    assign err_count        = err_count_r;
    assign drain.out_valid  = out_valid_r;
    assign drain.out_data   = out_data_r;
    assign drain.out_status = out_status_r;

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Bench for uart_rx_drain_ctrl: a queue-based FIFO model feeds the block and a scoreboard
// checks every character delivered over the output handshake.
module tb_uart_rx_drain_ctrl;
    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        rx_reset = 1'b0;
    logic        force_drain = 1'b0;
    logic        err_clr = 1'b0;
    logic [4:0]  rf_count = 5'd0;
    logic [10:0] rf_data_out = 11'd0;
    logic [9:0]  counter_t = 10'd500;
    logic [1:0]  fcr_trig = 2'b00;
    logic        rf_pop;
    logic        rda_int;
    logic        ti_int;
    logic        err_int;
    logic [7:0]  err_count;

    uart_rx_drain_ctrl_if drain_if ();

    uart_rx_drain_ctrl #(.FIFO_COUNTER_W(5), .REC_WIDTH(11), .BURST(8)) dut (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .rx_reset    (rx_reset),
        .rf_count    (rf_count),
        .rf_data_out (rf_data_out),
        .counter_t   (counter_t),
        .fcr_trig    (fcr_trig),
        .force_drain (force_drain),
        .err_clr     (err_clr),
        .rf_pop      (rf_pop),
        .rda_int     (rda_int),
        .ti_int      (ti_int),
        .err_int     (err_int),
        .err_count   (err_count),
        .drain       (drain_if)
    );

    always #5 clk = ~clk;

    logic [10:0] fifo_q[$];
    logic [10:0] wr_q[$];
    logic [10:0] exp_q[$];
    int          pop_times[$];
    int          total_cnt = 0;
    int          bad_cnt   = 0;
    int          cyc       = 0;
    int          xfer_cnt  = 0;
    int          exp_err   = 0;
    logic        prev_pop  = 1'b0;
    logic        hold_prev = 1'b0;
    logic [7:0]  held_data = 8'd0;
    logic [10:0] mdl_entry;
    logic [10:0] sb_entry;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic fifo_write(input logic [7:0] data, input logic [2:0] status);
        wr_q.push_back({data, status});
        exp_q.push_back({data, status});
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_rf_pop"},     32'(rf_pop),              32'd0);
        check_val({tag, "_out_valid"},  32'(drain_if.out_valid),  32'd0);
        check_val({tag, "_out_data"},   32'(drain_if.out_data),   32'd0);
        check_val({tag, "_out_status"}, 32'(drain_if.out_status), 32'd0);
        check_val({tag, "_rda_int"},    32'(rda_int),             32'd0);
        check_val({tag, "_ti_int"},     32'(ti_int),              32'd0);
        check_val({tag, "_err_int"},    32'(err_int),             32'd0);
        check_val({tag, "_err_count"},  32'(err_count),           32'd0);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (!(wr_q.size() == 0 && fifo_q.size() == 0 && !drain_if.out_valid && !rf_pop)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(n < budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pop(input string tag, input int budget);
        int n = 0;
        while (!rf_pop && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(rf_pop), 32'd1);
    endtask

    task automatic check_spacing(input string tag, input int burst_at);
        for (int i = 1; i < pop_times.size(); i++) begin
            check_val(tag, 32'(pop_times[i] - pop_times[i-1]), (i == burst_at) ? 32'd4 : 32'd2);
        end
    endtask

    // FIFO model and scoreboard, evaluated mid-cycle while DUT outputs are stable.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (wb_rst_i) begin
            fifo_q.delete();
            wr_q.delete();
            exp_q.delete();
            exp_err   = 0;
            prev_pop  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (drain_if.out_valid && drain_if.out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("sb_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    sb_entry = exp_q.pop_front();
                    check_val("sb_data",   32'(drain_if.out_data),   32'(sb_entry[10:3]));
                    check_val("sb_status", 32'(drain_if.out_status), 32'(sb_entry[2:0]));
                end
            end
            if (hold_prev) begin
                check_val("hold_data", 32'(drain_if.out_data), 32'(held_data));
            end
            hold_prev = drain_if.out_valid && !drain_if.out_ready;
            held_data = drain_if.out_data;
            if (rf_pop) begin
                check_val("pop_b2b", 32'(prev_pop), 32'd0);
                pop_times.push_back(cyc);
                if (fifo_q.size() == 0) begin
                    check_val("pop_empty", 32'(fifo_q.size()), 32'd1);
                end else begin
                    mdl_entry = fifo_q.pop_front();
                    if (mdl_entry[2:0] != 3'b000 && exp_err < 255) exp_err++;
                    check_val("err_count", 32'(err_count), 32'(exp_err));
                end
            end
            prev_pop = rf_pop;
            if (rx_reset) begin
                fifo_q.delete();
                exp_q.delete();
                hold_prev = 1'b0;
            end
            while (wr_q.size() != 0) fifo_q.push_back(wr_q.pop_front());
        end
        rf_count    = 5'(fifo_q.size());
        rf_data_out = (fifo_q.size() != 0) ? fifo_q[0] : 11'd0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc_w;
        int xfer_base;
        drain_if.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        wb_rst_i = 1'b0;
        @(negedge clk);

        // Trigger level 4: nothing at 3 entries, then four pops in FIFO order
        fcr_trig = 2'b01;
        drain_if.out_ready = 1'b1;
        pop_times.delete();
        fifo_write(8'h11, 3'b000);
        fifo_write(8'h22, 3'b000);
        fifo_write(8'h33, 3'b000);
        repeat (8) @(negedge clk);
        check_val("t1_no_pop_at3", 32'(pop_times.size()), 32'd0);
        check_val("t1_rda_low", 32'(rda_int), 32'd0);
        cyc_w = cyc;
        fifo_write(8'h44, 3'b000);
        @(negedge clk);
        check_val("t1_rda_high", 32'(rda_int), 32'd1);
        wait_drain("t1_drain_timeout", 50);
        check_val("t1_pops", 32'(pop_times.size()), 32'd4);
        check_val("t1_first_latency", 32'(pop_times[0] - cyc_w), 32'd3);
        check_spacing("t1_spacing", 0);
        check_val("t1_count0", 32'(rf_count), 32'd0);
        check_val("t1_rda_clear", 32'(rda_int), 32'd0);

        // Character timeout drains below the trigger
        fcr_trig = 2'b11;
        pop_times.delete();
        fifo_write(8'h5C, 3'b000);
        fifo_write(8'hC5, 3'b000);
        repeat (5) @(negedge clk);
        check_val("t2_no_pop", 32'(pop_times.size()), 32'd0);
        check_val("t2_ti_low", 32'(ti_int), 32'd0);
        counter_t = 10'd0;
        @(negedge clk);
        check_val("t2_ti_high", 32'(ti_int), 32'd1);
        wait_drain("t2_drain_timeout", 50);
        check_val("t2_pops", 32'(pop_times.size()), 32'd2);
        check_val("t2_ti_empty", 32'(ti_int), 32'd0);
        counter_t = 10'd500;

        // force_drain below the trigger
        pop_times.delete();
        fifo_write(8'h7E, 3'b000);
        repeat (4) @(negedge clk);
        check_val("t2f_no_pop", 32'(pop_times.size()), 32'd0);
        force_drain = 1'b1;
        wait_drain("t2f_drain_timeout", 50);
        check_val("t2f_pops", 32'(pop_times.size()), 32'd1);
        force_drain = 1'b0;

        // Back-pressure: one pop, held data, then the rest without loss
        fcr_trig = 2'b00;
        drain_if.out_ready = 1'b0;
        pop_times.delete();
        xfer_base = xfer_cnt;
        fifo_write(8'hA1, 3'b000);
        fifo_write(8'hB2, 3'b000);
        fifo_write(8'hC3, 3'b000);
        repeat (22) @(negedge clk);
        check_val("t3_one_pop", 32'(pop_times.size()), 32'd1);
        check_val("t3_valid", 32'(drain_if.out_valid), 32'd1);
        check_val("t3_head", 32'(drain_if.out_data), 32'h0000_00A1);
        drain_if.out_ready = 1'b1;
        wait_drain("t3_drain_timeout", 50);
        check_val("t3_pops", 32'(pop_times.size()), 32'd3);
        check_val("t3_xfers", 32'(xfer_cnt - xfer_base), 32'd3);
        check_val("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Burst limit: 8 pops, a pass through idle, then 4 more
        pop_times.delete();
        for (int i = 0; i < 12; i++) fifo_write(8'(8'h30 + i), 3'b000);
        wait_drain("t4_drain_timeout", 100);
        check_val("t4_pops", 32'(pop_times.size()), 32'd12);
        check_spacing("t4_spacing", 8);

        // Error status, sticky interrupt, clear priority, saturation
        fifo_write(8'h00, 3'b100);
        fifo_write(8'h5A, 3'b010);
        wait_drain("t5_drain_timeout", 50);
        check_val("t5_err_int", 32'(err_int), 32'd1);
        check_val("t5_err_count2", 32'(err_count), 32'd2);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_val("t5_err_cleared", 32'(err_int), 32'd0);
        fifo_write(8'hC3, 3'b001);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_val("t5_coincide_pop", 32'(rf_pop), 32'd1);
        check_val("t5_set_wins", 32'(err_int), 32'd1);
        check_val("t5_err_count3", 32'(err_count), 32'd3);
        wait_drain("t5_drain3_timeout", 50);
        for (int r = 0; r < 17; r++) begin
            for (int j = 0; j < 16; j++) fifo_write(8'(j), 3'b001);
            wait_drain("t5_sat_timeout", 100);
        end
        check_val("t5_saturated", 32'(err_count), 32'd255);

        // rx_reset while in the gap cycle with a held character
        drain_if.out_ready = 1'b0;
        pop_times.delete();
        fifo_write(8'h91, 3'b000);
        fifo_write(8'h92, 3'b000);
        fifo_write(8'h93, 3'b000);
        wait_pop("t6_first_pop", 10);
        check_val("t6_valid_before", 32'(drain_if.out_valid), 32'd1);
        rx_reset = 1'b1;
        @(negedge clk);
        rx_reset = 1'b0;
        check_val("t6_valid_cleared", 32'(drain_if.out_valid), 32'd0);
        check_val("t6_pop_cleared", 32'(rf_pop), 32'd0);
        check_val("t6_err_count_kept", 32'(err_count), 32'd255);
        check_val("t6_err_int_kept", 32'(err_int), 32'd1);
        repeat (5) @(negedge clk);
        check_val("t6_no_more_pops", 32'(pop_times.size()), 32'd1);
        drain_if.out_ready = 1'b1;
        pop_times.delete();
        cyc_w = cyc;
        fifo_write(8'h94, 3'b000);
        wait_drain("t6_drain_timeout", 50);
        check_val("t6_idle_latency", 32'(pop_times[0] - cyc_w), 32'd3);

        // Asynchronous reset in the middle of a burst
        pop_times.delete();
        for (int i = 0; i < 10; i++) fifo_write(8'(8'hE0 + i), 3'b000);
        while (pop_times.size() < 3) @(negedge clk);
        wait_pop("t7_mid_pop", 10);
        check_val("t7_rda_before", 32'(rda_int), 32'd1);
        #1;
        wb_rst_i = 1'b1;
        #1;
        check_outputs_zero("t7_async");
        @(negedge clk);
        @(negedge clk);
        wb_rst_i = 1'b0;
        @(negedge clk);
        fifo_write(8'h3C, 3'b000);
        wait_drain("t7_drain_timeout", 50);
        check_val("t7_err_count_after", 32'(err_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
